// File: rtl/up_down_counter_param.sv
// WIDTH-bit loadable up/down counter with programmable terminal value,
// wrap/saturate limit handling and registered overflow/underflow pulses.
module up_down_counter_param #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             sclr,
    input  logic             ld,
    input  logic [0:WIDTH-1] d_in,
    output logic [0:WIDTH-1] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (sclr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = (d_in > MAX_VAL) ? MAX_VAL : d_in;
        end else if (en) begin
            if (mode) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    count_d = sat ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                // Wrap goes to MAX_VAL, not to the all-ones pattern.
                if (at_zero) begin
                    udf_d   = 1'b1;
                    count_d = sat ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
    assign tc    = mode ? at_max : at_zero;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Bench for up_down_counter_param: three parameter sets share one control
// stream; a per-instance behavioural model is compared on every negedge.
module tb_up_down_counter_param;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic en = 1'b0, mode = 1'b1, sat = 1'b0, sclr = 1'b0, ld = 1'b0;
    logic [0:7]  d9 = '0, d255 = '0;
    logic [0:11] d1k = '0;
    logic [0:7]  c9, c255;
    logic [0:11] c1k;
    logic tc9, tc255, tc1k;
    logic ovf9, ovf255, ovf1k;
    logic udf9, udf255, udf1k;

    int errors = 0;
    int checks = 0;

    int mx[3] = '{9, 255, 1000};
    int m_cnt[3];
    bit m_ovf[3];
    bit m_udf[3];

    always #5 clk = ~clk;

    up_down_counter_param #(.WIDTH(8), .MAX_VAL(8'd9)) u9 (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .sat(sat),
        .sclr(sclr), .ld(ld), .d_in(d9), .count(c9), .tc(tc9),
        .ovf(ovf9), .udf(udf9));

    up_down_counter_param #(.WIDTH(8)) u255 (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .sat(sat),
        .sclr(sclr), .ld(ld), .d_in(d255), .count(c255), .tc(tc255),
        .ovf(ovf255), .udf(udf255));

    up_down_counter_param #(.WIDTH(12), .MAX_VAL(12'd1000)) u1k (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .sat(sat),
        .sclr(sclr), .ld(ld), .d_in(d1k), .count(c1k), .tc(tc1k),
        .ovf(ovf1k), .udf(udf1k));

    function automatic int din_of(int i);
        if (i == 0) return int'(d9);
        if (i == 1) return int'(d255);
        return int'(d1k);
    endfunction

    // Model: count range 0..max, step by +/-1, limit events flagged.
    always @(posedge clk or negedge clr) begin
        for (int i = 0; i < 3; i++) begin
            m_ovf[i] <= 1'b0;
            m_udf[i] <= 1'b0;
            if (!clr || sclr) begin
                m_cnt[i] <= 0;
            end else if (ld) begin
                m_cnt[i] <= (din_of(i) > mx[i]) ? mx[i] : din_of(i);
            end else if (en && mode) begin
                if (m_cnt[i] < mx[i]) m_cnt[i] <= m_cnt[i] + 1;
                else begin
                    m_ovf[i] <= 1'b1;
                    m_cnt[i] <= sat ? mx[i] : 0;
                end
            end else if (en) begin
                if (m_cnt[i] > 0) m_cnt[i] <= m_cnt[i] - 1;
                else begin
                    m_udf[i] <= 1'b1;
                    m_cnt[i] <= sat ? 0 : mx[i];
                end
            end
        end
    end

    task automatic cmp(string nm, int i, int c, logic t, logic o, logic u);
        int et;
        et = mode ? int'(m_cnt[i] == mx[i]) : int'(m_cnt[i] == 0);
        checks++;
        if (c != m_cnt[i] || int'(t) != et ||
            o != m_ovf[i] || u != m_udf[i]) begin
            errors++;
            $display("FAIL %s @%0t: got cnt=%0d tc=%0d ovf=%0d udf=%0d, want cnt=%0d tc=%0d ovf=%0d udf=%0d",
                     nm, $time, c, t, o, u, m_cnt[i], et, m_ovf[i], m_udf[i]);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_u9", 0, int'(c9), tc9, ovf9, udf9);
        cmp("model_u255", 1, int'(c255), tc255, ovf255, udf255);
        cmp("model_u1k", 2, int'(c1k), tc1k, ovf1k, udf1k);
    end

    task automatic lit(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int novf;

    initial begin
        #3;
        lit("rst_cnt", int'(c9), 0);
        lit("rst_tc_up", int'(tc9), 0);
        lit("rst_ovf", int'(ovf1k), 0);
        repeat (2) step();
        clr = 1'b1;

        // Reset / clear mid-count
        ld = 1; d9 = 30; d255 = 30; d1k = 30;
        step();
        ld = 0; en = 1; mode = 1;
        repeat (7) step();
        lit("run_to_37", int'(c1k), 37);
        #2 clr = 1'b0;
        #1;
        lit("async_clr_cnt", int'(c1k), 0);
        lit("async_clr_ovf", int'(ovf9), 0);
        lit("async_clr_udf", int'(udf1k), 0);
        clr = 1'b1; en = 0;
        step();
        sclr = 1;
        step();
        sclr = 0;
        lit("sclr_zero", int'(c1k), 0);

        // Up wrap, MAX_VAL=9
        ld = 1; d9 = 7;
        step();
        ld = 0; en = 1; mode = 1; sat = 0;
        step(); lit("up_8", int'(c9), 8);
        step(); lit("up_9", int'(c9), 9); lit("up_tc", int'(tc9), 1);
        step(); lit("wrap_0", int'(c9), 0); lit("wrap_ovf", int'(ovf9), 1);
        step(); lit("after_1", int'(c9), 1); lit("ovf_drop", int'(ovf9), 0);

        // Down wrap then saturate
        en = 0; ld = 1; d9 = 1;
        step();
        ld = 0; en = 1; mode = 0;
        step(); lit("dn_0", int'(c9), 0); lit("dn_tc", int'(tc9), 1);
        step(); lit("dn_wrap9", int'(c9), 9); lit("dn_udf", int'(udf9), 1);
        en = 0; ld = 1; d9 = 0; sat = 1;
        step();
        ld = 0; en = 1;
        step(); lit("sat_0a", int'(c9), 0); lit("sat_udf_a", int'(udf9), 1);
        step(); lit("sat_0b", int'(c9), 0); lit("sat_udf_b", int'(udf9), 1);
        en = 0;
        step(); lit("sat_udf_off", int'(udf9), 0);

        // Load clamp and priority
        ld = 1; d9 = 200; en = 1; mode = 1;
        step(); lit("ld_clamp", int'(c9), 9); lit("ld_no_ovf", int'(ovf9), 0);
        sclr = 1; d9 = 5;
        step(); lit("sclr_over_ld", int'(c9), 0);
        sclr = 0; ld = 0; en = 0; sat = 0;

        // Full range, default MAX_VAL
        ld = 1; d255 = 254;
        step();
        ld = 0; en = 1; mode = 1;
        step(); lit("fr_255", int'(c255), 255);
        step(); lit("fr_0", int'(c255), 0); lit("fr_ovf", int'(ovf255), 1);
        lit("fr_tc_up", int'(tc255), 0);
        mode = 0;
        #1 lit("fr_tc_dn", int'(tc255), 1);
        step(); lit("fr_udf255", int'(c255), 255); lit("fr_udf", int'(udf255), 1);
        en = 0;

        // 1001 up steps on MAX_VAL=1000
        sclr = 1;
        step();
        sclr = 0; en = 1; mode = 1; sat = 0;
        novf = 0;
        for (int k = 0; k < 1001; k++) begin
            step();
            if (ovf1k) novf++;
        end
        lit("k_back_0", int'(c1k), 0);
        lit("k_one_ovf", novf, 1);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            en   = $urandom_range(0, 3) != 0;
            mode = $urandom_range(0, 1) != 0;
            sat  = $urandom_range(0, 1) != 0;
            ld   = $urandom_range(0, 15) == 0;
            sclr = $urandom_range(0, 31) == 0;
            d9   = 8'($urandom);
            d255 = 8'($urandom);
            d1k  = 12'($urandom);
            step();
        end
        en = 0; ld = 0; sclr = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_down_counter_param.md
# up_down_counter_param

Parametrised successor to the 8-bit up/down counter: a WIDTH-bit loadable up/down counter with programmable terminal value, wrap or saturate mode, synchronous clear, count enable, and registered overflow/underflow event pulses. It is the general-purpose event/timebase counter for the datapath blocks and replaces fixed-width instances.

## Interface

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: terminal (largest) count value; legal range 1..2**WIDTH-1. The count range is 0..MAX_VAL.

Ports (vectors are declared [0:WIDTH-1]; index 0 is the MSB):
- clk  in  1  rising-edge clock; the block has one clock.
- clr  in  1  reset, asynchronous, active-low; clr=0 clears all state immediately.
- en  in  1  count enable.
- mode  in  1  direction: 1 = up, 0 = down.
- sat  in  1  limit behaviour: 1 = saturate at the limit, 0 = wrap.
- sclr  in  1  synchronous clear, active-high.
- ld  in  1  synchronous load of d_in.
- d_in  in  WIDTH  load value.
- count  out  WIDTH  current count; registered.
- tc  out  1  terminal-count flag; combinational from count and mode.
- ovf  out  1  overflow event; registered one-cycle pulse.
- udf  out  1  underflow event; registered one-cycle pulse.

## Operation

- Reset (clr=0, asynchronous): count=0, ovf=0, udf=0. With count=0, tc=1 if mode=0 and tc=0 if mode=1. Deassertion takes effect at the next clk edge.
- Per-edge priority is sclr > ld > en > hold.
- sclr=1: count←0, ovf←0, udf←0.
- ld=1: count←d_in if d_in≤MAX_VAL, else count←MAX_VAL (clamp). ovf←0, udf←0. Load ignores en.
- en=1, mode=1:
  - count<MAX_VAL: count←count+1.
  - count=MAX_VAL, sat=0: count←0 and ovf←1.
  - count=MAX_VAL, sat=1: count holds MAX_VAL and ovf←1.
- en=1, mode=0:
  - count>0: count←count−1.
  - count=0, sat=0: count←MAX_VAL and udf←1.
  - count=0, sat=1: count holds 0 and udf←1.
- Hold (no sclr/ld/en): count holds; ovf←0, udf←0.
- ovf and udf are never both 1 in the same cycle. Each is high for exactly one cycle per limit event. With en held at the limit in saturate mode, the flag is re-asserted every cycle.
- tc = (mode & count==MAX_VAL) | (~mode & count==0). A change of mode updates tc in the same cycle, with no edge needed.
- Arithmetic is WIDTH bits, unsigned. The +1 and −1 results are never used out of range: the wrap is to MAX_VAL, not to 2**WIDTH−1, when MAX_VAL<2**WIDTH−1.
- mode and sat may change on any cycle; they take effect on the next edge.

## Timing

- Latency from an active control (sclr/ld/en) to count: 1 clk edge. ovf/udf assert on the same edge that applies the limit step.
- tc has zero cycles of latency from count/mode; it is combinational only.
- An asynchronous clr assertion mid-count forces the reset values within the same cycle, independent of clk.
- clr release must meet recovery/removal to clk. The first count step occurs on the first edge at which clr=1 and en=1.
- Simultaneous ld and en: the load wins and no step occurs that cycle. Simultaneous sclr and ld: the clear wins.

## Test plan

- Reset/clear: run to count=37, assert clr=0 between edges → count=0 and ovf=udf=0 immediately; release, sclr=1 for one edge → count stays 0.
- Up wrap (WIDTH=8, MAX_VAL=9): load 7, en=1, mode=1 → count 8, 9 (tc=1), 0 with ovf=1 for exactly one cycle, then 1 with ovf=0.
- Down wrap and saturate (MAX_VAL=9): load 1, mode=0, sat=0 → count 0, then 9 with udf=1. Reload 0, sat=1 → count stays 0 with udf=1 every cycle; drop en → udf=0.
- Load clamp and priority (MAX_VAL=9): ld=1, d_in=200, en=1 → count=9 with no step. Next cycle, sclr=1 with ld=1, d_in=5 → count=0.
- Default full range (WIDTH=8, MAX_VAL=255): load 254, up → 255 then 0 with ovf=1. Flip mode to 0 at count=0 → tc goes 0→1 in the same cycle, and the next edge gives count=255 with udf=1.
- Wide/odd parameters (WIDTH=12, MAX_VAL=1000): 1001 up steps from 0 → count returns to 0 with exactly one ovf pulse. Compare against a reference model over 10k random en/mode/sat/ld/sclr cycles.
